// File: rtl/core_exec_sequencer.sv
// Sequences one program run on the HlangPU core: hold core reset, present the start
// address, enable execution until halt/timeout/abort, then report cycles and outcome.
module core_exec_sequencer #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned RST_CYCLES = 4
) (
    input  logic                  CCLK,
    input  logic                  CRST,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [CNT_WIDTH-1:0]  CMD_TIMEOUT,
    input  logic                  ABORT,
    output logic                  CORE_RST,
    output logic                  CORE_EXEC,
    output logic [ADDR_WIDTH-1:0] CORE_MEM_ADDR,
    input  logic                  CORE_STAT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  TIMED_OUT,
    output logic [CNT_WIDTH-1:0]  CYCLES
);

    localparam int unsigned       RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RCW-1:0]    RST_LAST = RCW'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t               r_state;
    logic [RCW-1:0]       r_rst_cnt;
    logic [CNT_WIDTH-1:0] r_timeout;
    logic                 r_first_run;

    logic [CNT_WIDTH-1:0] w_cycles_inc;
    logic                 w_stat_hit;
    logic                 w_timeout_hit;

    // Saturating cycle count; halt status from the previous run is masked in the first RUN cycle.
    assign w_cycles_inc  = (CYCLES == CNT_MAX) ? CYCLES : CYCLES + CNT_WIDTH'(1);
    assign w_stat_hit    = CORE_STAT && !r_first_run;
    assign w_timeout_hit = (r_timeout != '0) && (w_cycles_inc == r_timeout);

    always_ff @(posedge CCLK or posedge CRST) begin
        if (CRST) begin
            r_state       <= S_IDLE;
            r_rst_cnt     <= '0;
            r_timeout     <= '0;
            r_first_run   <= 1'b0;
            CMD_READY     <= 1'b0;
            CORE_RST      <= 1'b1;
            CORE_EXEC     <= 1'b0;
            CORE_MEM_ADDR <= '0;
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            TIMED_OUT     <= 1'b0;
            CYCLES        <= '0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        r_state       <= S_RESET;
                        r_rst_cnt     <= '0;
                        r_timeout     <= CMD_TIMEOUT;
                        CMD_READY     <= 1'b0;
                        BUSY          <= 1'b1;
                        CORE_RST      <= 1'b1;
                        CORE_MEM_ADDR <= CMD_ADDR;
                        CYCLES        <= '0;
                        TIMED_OUT     <= 1'b0;
                    end else begin
                        CMD_READY <= 1'b1;
                        CORE_RST  <= 1'b0;
                    end
                end
                S_RESET: begin
                    if (ABORT) begin
                        r_state  <= S_FINISH;
                        CORE_RST <= 1'b0;
                        DONE     <= 1'b1;
                    end else if (r_rst_cnt == RST_LAST) begin
                        r_state  <= S_LAUNCH;
                        CORE_RST <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + RCW'(1);
                    end
                end
                S_LAUNCH: begin
                    if (ABORT) begin
                        r_state <= S_FINISH;
                        DONE    <= 1'b1;
                    end else begin
                        r_state     <= S_RUN;
                        CORE_EXEC   <= 1'b1;
                        r_first_run <= 1'b1;
                    end
                end
                S_RUN: begin
                    CYCLES      <= w_cycles_inc;
                    r_first_run <= 1'b0;
                    // Priority: abort, then halt status, then timeout.
                    if (ABORT || w_stat_hit || w_timeout_hit) begin
                        r_state   <= S_FINISH;
                        CORE_EXEC <= 1'b0;
                        DONE      <= 1'b1;
                        TIMED_OUT <= !ABORT && !w_stat_hit;
                    end
                end
                S_FINISH: begin
                    r_state   <= S_IDLE;
                    BUSY      <= 1'b0;
                    CMD_READY <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    CORE_RST  <= 1'b0;
                    CORE_EXEC <= 1'b0;
                    BUSY      <= 1'b0;
                    CMD_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule
